// File: rtl/traffic_fsm_pkg.sv
// Shared types and constants for the traffic-light controller: state encoding,
// timer interval codes and lamp bit positions/patterns.
package traffic_fsm_pkg;

    typedef enum logic [2:0] {
        StMgBase = 3'd0,
        StMgExt  = 3'd1,
        StMy     = 3'd2,
        StWalk   = 3'd3,
        StSgBase = 3'd4,
        StSgExt  = 3'd5,
        StSy     = 3'd6
    } state_e;

    localparam logic [1:0] T_BASE = 2'b00;
    localparam logic [1:0] T_EXT  = 2'b01;
    localparam logic [1:0] T_YEL  = 2'b10;

    localparam int unsigned LED_MAIN_RED    = 6;
    localparam int unsigned LED_MAIN_YELLOW = 5;
    localparam int unsigned LED_MAIN_GREEN  = 4;
    localparam int unsigned LED_SIDE_RED    = 3;
    localparam int unsigned LED_SIDE_YELLOW = 2;
    localparam int unsigned LED_SIDE_GREEN  = 1;
    localparam int unsigned LED_WALK        = 0;

    localparam logic [6:0] LEDS_MG   = 7'((1 << LED_MAIN_GREEN) | (1 << LED_SIDE_RED));
    localparam logic [6:0] LEDS_MY   = 7'((1 << LED_MAIN_YELLOW) | (1 << LED_SIDE_RED));
    localparam logic [6:0] LEDS_WALK = 7'((1 << LED_MAIN_RED) | (1 << LED_SIDE_RED)
                                          | (1 << LED_WALK));
    localparam logic [6:0] LEDS_SG   = 7'((1 << LED_MAIN_RED) | (1 << LED_SIDE_GREEN));
    localparam logic [6:0] LEDS_SY   = 7'((1 << LED_MAIN_RED) | (1 << LED_SIDE_YELLOW));

endpackage

// File: rtl/traffic_fsm.sv
// Main/side-street traffic-light controller with pedestrian walk phase, driving an
// external interval timer through start_timer/interval and sequencing on its expiry.
module traffic_fsm
    import traffic_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       Reset_Sync,
    input  logic       Prog_Sync,
    input  logic       Sensor_Sync,
    input  logic       WR,
    input  logic       expired,
    output logic       start_timer,
    output logic [1:0] interval,
    output logic       WR_Reset,
    output logic [6:0] LEDs
);

    state_e r_state;
    state_e w_next_state;
    logic   r_start_timer;
    logic   w_advance;

    // Every state change (including recovery from a bad encoding) re-arms the timer.
    always_ff @(posedge clk) begin
        if (Reset_Sync || Prog_Sync) begin
            r_state       <= StMgBase;
            r_start_timer <= 1'b1;
        end else begin
            r_state       <= w_next_state;
            r_start_timer <= (w_next_state != r_state);
        end
    end

    assign start_timer = r_start_timer;

    // expired may still be high from the previous interval while the timer reloads.
    assign w_advance = expired && !r_start_timer;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            StMgBase: if (w_advance) w_next_state = StMgExt;
            StMgExt:  if (w_advance) w_next_state = StMy;
            StMy:     if (w_advance) w_next_state = WR ? StWalk : StSgBase;
            StWalk:   if (w_advance) w_next_state = StSgBase;
            StSgBase: if (w_advance) w_next_state = Sensor_Sync ? StSgExt : StSy;
            StSgExt:  if (w_advance) w_next_state = StSy;
            StSy:     if (w_advance) w_next_state = StMgBase;
            default:  w_next_state = StMgBase;
        endcase
    end

    always_comb begin
        interval = T_BASE;
        LEDs     = LEDS_MG;
        WR_Reset = 1'b0;
        case (r_state)
            StMgBase: begin
                interval = T_BASE;
                LEDs     = LEDS_MG;
            end
            StMgExt: begin
                interval = Sensor_Sync ? T_EXT : T_BASE;
                LEDs     = LEDS_MG;
            end
            StMy: begin
                interval = T_YEL;
                LEDs     = LEDS_MY;
            end
            StWalk: begin
                interval = T_EXT;
                LEDs     = LEDS_WALK;
                WR_Reset = 1'b1;
            end
            StSgBase: begin
                interval = T_BASE;
                LEDs     = LEDS_SG;
            end
            StSgExt: begin
                interval = T_EXT;
                LEDs     = LEDS_SG;
            end
            StSy: begin
                interval = T_YEL;
                LEDs     = LEDS_SY;
            end
            default: begin
                interval = T_BASE;
                LEDs     = LEDS_MG;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_fsm.sv
// Directed bench for traffic_fsm: normal cycle, sensor extension, walk phase,
// stale-expired handling and reset/program aborts, with hand-computed expectations.
module tb_traffic_fsm;

    logic       clk = 1'b0;
    logic       Reset_Sync = 1'b0;
    logic       Prog_Sync = 1'b0;
    logic       Sensor_Sync = 1'b0;
    logic       WR = 1'b0;
    logic       expired = 1'b0;
    logic       start_timer;
    logic [1:0] interval;
    logic       WR_Reset;
    logic [6:0] LEDs;

    int n_checks = 0;
    int n_errors = 0;

    traffic_fsm dut (
        .clk        (clk),
        .Reset_Sync (Reset_Sync),
        .Prog_Sync  (Prog_Sync),
        .Sensor_Sync(Sensor_Sync),
        .WR         (WR),
        .expired    (expired),
        .start_timer(start_timer),
        .interval   (interval),
        .WR_Reset   (WR_Reset),
        .LEDs       (LEDs)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_Sync = 1'b1;
        tick();
        Reset_Sync = 1'b0;
        tick();
    endtask

    // One expired pulse; on return the new state is in its start_timer cycle.
    task automatic advance();
        expired = 1'b1;
        tick();
        expired = 1'b0;
    endtask

    task automatic test_reset();
        Sensor_Sync = 1'b0;
        WR          = 1'b0;
        Reset_Sync  = 1'b1;
        expired     = 1'b1;
        tick();
        tick();
        n_checks++;
        if (LEDs !== 7'b0011000) begin
            n_errors++;
            $display("FAIL reset_leds got=%b want=0011000", LEDs);
        end
        n_checks++;
        if (interval !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_interval got=%b want=00", interval);
        end
        n_checks++;
        if (WR_Reset !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_wr_reset got=%b want=0", WR_Reset);
        end
        Reset_Sync = 1'b0;
        expired    = 1'b0;
        n_checks++;
        if (start_timer !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_start_first got=%b want=1", start_timer);
        end
        tick();
        n_checks++;
        if (start_timer !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_start_second got=%b want=0", start_timer);
        end
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (LEDs !== 7'b0011000 || start_timer !== 1'b0 || interval !== 2'b00) begin
            n_errors++;
            $display("FAIL hold_idle got leds=%b st=%b int=%b want leds=0011000 st=0 int=00",
                     LEDs, start_timer, interval);
        end
    endtask

    task automatic test_basic_cycle();
        logic [6:0] exp_leds [5];
        logic [1:0] exp_int  [5];
        exp_leds = '{7'b0011000, 7'b0101000, 7'b1000010, 7'b1000100, 7'b0011000};
        exp_int  = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
        Sensor_Sync = 1'b0;
        WR          = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            advance();
            n_checks++;
            if (LEDs !== exp_leds[i] || interval !== exp_int[i] || start_timer !== 1'b1) begin
                n_errors++;
                $display("FAIL basic_step%0d got leds=%b int=%b st=%b want leds=%b int=%b st=1",
                         i, LEDs, interval, start_timer, exp_leds[i], exp_int[i]);
            end
            tick();
            n_checks++;
            if (start_timer !== 1'b0 || LEDs !== exp_leds[i]) begin
                n_errors++;
                $display("FAIL basic_pulse%0d got st=%b leds=%b want st=0 leds=%b",
                         i, start_timer, LEDs, exp_leds[i]);
            end
        end
    endtask

    task automatic test_sensor();
        logic [6:0] exp_leds [6];
        logic [1:0] exp_int  [6];
        exp_leds = '{7'b0011000, 7'b0101000, 7'b1000010, 7'b1000010, 7'b1000100, 7'b0011000};
        exp_int  = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
        Sensor_Sync = 1'b1;
        WR          = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            advance();
            tick();
            n_checks++;
            if (LEDs !== exp_leds[i] || interval !== exp_int[i]) begin
                n_errors++;
                $display("FAIL sensor_step%0d got leds=%b int=%b want leds=%b int=%b",
                         i, LEDs, interval, exp_leds[i], exp_int[i]);
            end
        end
        Sensor_Sync = 1'b0;
    endtask

    task automatic test_walk();
        Sensor_Sync = 1'b0;
        WR          = 1'b1;
        do_reset();
        advance();
        tick();
        advance();
        tick();
        advance();
        n_checks++;
        if (LEDs !== 7'b1001001 || interval !== 2'b01 || WR_Reset !== 1'b1) begin
            n_errors++;
            $display("FAIL walk_entry got leds=%b int=%b wrr=%b want leds=1001001 int=01 wrr=1",
                     LEDs, interval, WR_Reset);
        end
        tick();
        WR = 1'b0;
        n_checks++;
        if (WR_Reset !== 1'b1) begin
            n_errors++;
            $display("FAIL walk_wr_reset_hold got=%b want=1", WR_Reset);
        end
        advance();
        n_checks++;
        if (LEDs !== 7'b1000010 || WR_Reset !== 1'b0 || interval !== 2'b00) begin
            n_errors++;
            $display("FAIL walk_exit got leds=%b wrr=%b int=%b want leds=1000010 wrr=0 int=00",
                     LEDs, WR_Reset, interval);
        end
        tick();
    endtask

    task automatic test_stale_expired();
        Sensor_Sync = 1'b1;
        WR          = 1'b0;
        do_reset();
        expired = 1'b1;
        tick();
        tick();
        n_checks++;
        if (interval !== 2'b01 || LEDs !== 7'b0011000 || start_timer !== 1'b0) begin
            n_errors++;
            $display("FAIL stale_ignored got int=%b leds=%b st=%b want int=01 leds=0011000 st=0",
                     interval, LEDs, start_timer);
        end
        tick();
        expired = 1'b0;
        n_checks++;
        if (LEDs !== 7'b0101000 || start_timer !== 1'b1) begin
            n_errors++;
            $display("FAIL stale_next got leds=%b st=%b want leds=0101000 st=1",
                     LEDs, start_timer);
        end
        tick();
        n_checks++;
        if (LEDs !== 7'b0101000 || start_timer !== 1'b0) begin
            n_errors++;
            $display("FAIL stale_single_pulse got leds=%b st=%b want leds=0101000 st=0",
                     LEDs, start_timer);
        end
        Sensor_Sync = 1'b0;
    endtask

    task automatic test_abort();
        // Prog_Sync in SG_EXT
        Sensor_Sync = 1'b1;
        WR          = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            advance();
            tick();
        end
        n_checks++;
        if (LEDs !== 7'b1000010 || interval !== 2'b01) begin
            n_errors++;
            $display("FAIL abort_reach_sgext got leds=%b int=%b want leds=1000010 int=01",
                     LEDs, interval);
        end
        Prog_Sync = 1'b1;
        tick();
        Prog_Sync = 1'b0;
        n_checks++;
        if (LEDs !== 7'b0011000 || WR_Reset !== 1'b0 || start_timer !== 1'b1) begin
            n_errors++;
            $display("FAIL prog_abort got leds=%b wrr=%b st=%b want leds=0011000 wrr=0 st=1",
                     LEDs, WR_Reset, start_timer);
        end
        tick();
        // Reset_Sync in WALK
        Sensor_Sync = 1'b0;
        WR          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
            tick();
        end
        n_checks++;
        if (WR_Reset !== 1'b1 || LEDs !== 7'b1001001) begin
            n_errors++;
            $display("FAIL abort_reach_walk got wrr=%b leds=%b want wrr=1 leds=1001001",
                     WR_Reset, LEDs);
        end
        Reset_Sync = 1'b1;
        tick();
        Reset_Sync = 1'b0;
        n_checks++;
        if (LEDs !== 7'b0011000 || WR_Reset !== 1'b0 || start_timer !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_abort got leds=%b wrr=%b st=%b want leds=0011000 wrr=0 st=1",
                     LEDs, WR_Reset, start_timer);
        end
        tick();
        // Prog_Sync wins over expired in MY
        advance();
        tick();
        advance();
        tick();
        Prog_Sync = 1'b1;
        expired   = 1'b1;
        tick();
        Prog_Sync = 1'b0;
        expired   = 1'b0;
        n_checks++;
        if (LEDs !== 7'b0011000 || WR_Reset !== 1'b0 || interval !== 2'b00) begin
            n_errors++;
            $display("FAIL prog_priority got leds=%b wrr=%b int=%b want leds=0011000 wrr=0 int=00",
                     LEDs, WR_Reset, interval);
        end
        WR = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_cycle();
        test_sensor();
        test_walk();
        test_stale_expired();
        test_abort();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
